instr_fetch_unit: RTL

//  Fetch stage ahead of the decode/control path of the RISC-V core. Owns the fetch PC, issues

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/instr_fetch_unit_fifo.sv | 70 +++++++
 rtl/instr_fetch_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types and sizing helpers for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        FAULT = 2'd3
    } ifu_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INSTR_W          = 32;
    localparam int          ENTRY_W          = 2 * INSTR_W;

    // Occupancy counters must hold the value DEPTH itself, hence the extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous prefetch FIFO holding {pc, instr} pairs; flush clears all entries in one cycle.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CW    = cnt_width(DEPTH),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_data_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic [ENTRY_W-1:0] head_data_o,
    output logic               valid_o,
    output logic [CW-1:0]      count_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               do_pop;

    assign do_pop = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push_i) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is meaningful.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign valid_o     = (count_q != '0);
    assign count_o     = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited imem reads, buffers words for decode.
// Optional macro IFU_MISALIGN_EN enables the FAULT state for misaligned redirect targets.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic               imem_req_o,
    output logic [31:0]        imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               redirect_valid_i,
    input  logic [31:0]        redirect_pc_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [INSTR_W-1:0] instr_data_o,
    output logic [31:0]        instr_pc_o,
    output logic               fetch_fault_o
);

    localparam int          CW      = cnt_width(DEPTH);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    ifu_state_e     state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]  outst_q, outst_d;
    logic [31:0]    pcq_mem_q [DEPTH];
    logic [AW-1:0]  pcq_wr_q, pcq_wr_d;
    logic [AW-1:0]  pcq_rd_q, pcq_rd_d;

    logic               fifo_valid;
    logic [CW-1:0]      fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic               pop, grant, resp, push;
    logic [CW:0]        credit_used;
    logic [31:0]        redir_pc;
    logic               redir_bad;

`ifdef IFU_MISALIGN_EN
    assign redir_pc  = redirect_pc_i;
    assign redir_bad = |redirect_pc_i[1:0];
`else
    logic unused_redir_lsbs;
    assign unused_redir_lsbs = ^redirect_pc_i[1:0];
    assign redir_pc          = {redirect_pc_i[31:2], 2'b00};
    assign redir_bad         = 1'b0;
`endif

    assign pop   = fifo_valid && instr_ready_i;
    assign grant = imem_req_o && imem_gnt_i;
    assign resp  = imem_rvalid_i && (outst_q != '0);
    assign push  = resp && (state_q == FETCH) && !redirect_valid_i;

    // A pop this cycle frees a slot; once raised, req stays up until granted because
    // in-flight plus buffered words never grows without a grant.
    assign credit_used = {1'b0, outst_q} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
    assign imem_req_o  = (state_q == FETCH) && (credit_used < DEPTH_C);
    assign imem_addr_o = (state_q == FETCH) ? fetch_pc_q : '0;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q + CW'(grant) - CW'(resp);
        pcq_wr_d   = pcq_wr_q;
        pcq_rd_d   = pcq_rd_q;

        if (grant) begin
            pcq_wr_d   = pcq_wr_q + AW'(1);
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (push) begin
            pcq_rd_d = pcq_rd_q + AW'(1);
        end

        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = FETCH;
            DRAIN:   state_d = (outst_d == '0) ? FETCH : DRAIN;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase

        // Responses still owed after a redirect are dropped in DRAIN/FAULT, so the
        // PC queue restarts empty and is never touched until fetching resumes.
        if (redirect_valid_i) begin
            pcq_wr_d = '0;
            pcq_rd_d = '0;
            if (redir_bad) begin
                fetch_pc_d = fetch_pc_q;
                state_d    = FAULT;
            end else begin
                fetch_pc_d = redir_pc;
                state_d    = (outst_d != '0) ? DRAIN : FETCH;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            pcq_wr_q   <= pcq_wr_d;
            pcq_rd_q   <= pcq_rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant && !redirect_valid_i) begin
            pcq_mem_q[pcq_wr_q] <= fetch_pc_q;
        end
    end

    ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (push),
        .push_data_i ({pcq_mem_q[pcq_rd_q], imem_rdata_i}),
        .pop_i       (pop),
        .flush_i     (redirect_valid_i),
        .head_data_o (fifo_head),
        .valid_o     (fifo_valid),
        .count_o     (fifo_count)
    );

    assign instr_valid_o = fifo_valid;
    assign instr_pc_o    = fifo_valid ? fifo_head[ENTRY_W-1:INSTR_W] : '0;
    assign instr_data_o  = fifo_valid ? fifo_head[INSTR_W-1:0] : '0;

`ifdef IFU_MISALIGN_EN
    assign fetch_fault_o = (state_q == FAULT);
`else
    assign fetch_fault_o = 1'b0;
`endif

endmodule
